// File: rtl/mul_pkg.sv
// Shared types and widths for the shift-and-add multiplier and its adder.
package mul_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MUL_W  = 8;
  localparam int PROD_W = 2 * MUL_W;
endpackage

// File: rtl/adder16_cla.sv
// Combinational 16-bit two-level carry-lookahead adder: four 4-bit groups
// with group generate/propagate feeding a second lookahead level.
module adder16_cla (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum
);
  logic [15:0] g, pr, c;
  logic [3:0]  gg, gp, gc;

  assign g  = a & b;
  assign pr = a ^ b;

  // Group carries resolved in one lookahead step from cin.
  assign gc[0] = cin;
  assign gc[1] = gg[0] | (gp[0] & cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin);

  for (genvar k = 0; k < 4; k++) begin : g_grp
    logic [3:0] gi, pi, ci;
    assign gi = g[4*k +: 4];
    assign pi = pr[4*k +: 4];

    assign ci[0] = gc[k];
    assign ci[1] = gi[0] | (pi[0] & gc[k]);
    assign ci[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & gc[k]);
    assign ci[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
                 | (pi[2] & pi[1] & pi[0] & gc[k]);

    assign gg[k] = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
                 | (pi[3] & pi[2] & pi[1] & gi[0]);
    assign gp[k] = &pi;

    assign c[4*k +: 4] = ci;
  end

  assign sum = pr ^ c;
endmodule

// File: rtl/shift_add_mul.sv
// Sequential unsigned shift-and-add multiplier: W iterations per product,
// accumulation through the 16-bit CLA when the product width is 16.
module shift_add_mul
  import mul_pkg::*;
#(
  parameter int W = MUL_W
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p
);
  localparam int PW = 2 * W;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t          state, state_nxt;
  logic [PW-1:0]   mcand, acc, addend, acc_nxt;
  logic [W-1:0]    mult;
  logic [CW-1:0]   cnt;
  logic            last;

  assign addend = mult[0] ? mcand : '0;
  assign last   = (cnt == CW'(W - 1));

  // The CLA is fixed at 16 bits; other widths fall back to a plain adder.
  if (PW == 16) begin : g_cla
    adder16_cla u_add (
      .a   (acc),
      .b   (addend),
      .cin (1'b0),
      .sum (acc_nxt)
    );
  end else begin : g_gen
    assign acc_nxt = acc + addend;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      mcand <= '0;
      mult  <= '0;
      acc   <= '0;
      cnt   <= '0;
      p     <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (start) begin
          mcand <= {{W{1'b0}}, a};
          mult  <= b;
          acc   <= '0;
          cnt   <= '0;
        end
        RUN: begin
          acc   <= acc_nxt;
          mcand <= mcand << 1;
          mult  <= mult >> 1;
          cnt   <= cnt + 1'b1;
          if (last) p <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
endmodule

// File: tb/tb_shift_add_mul.sv
// Bench for shift_add_mul: vector table plus hand-written handshake and reset
// sequences, with a done-driven scoreboard checking every delivered product.
module tb_shift_add_mul;
  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [15:0] p;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] sb[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;
  vec_t vecs[8];

  shift_add_mul #(.W(8)) dut (
    .clk   (clk),
    .nrst  (nrst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding product.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) check("unexpected_done", 32'(done), 32'd0);
      else check("sb_product", 32'(p), 32'(sb.pop_front()));
    end
  end

  task automatic run_op(input logic [7:0] ai, input logic [7:0] bi, input logic [15:0] exp);
    int lat;
    lat = 0;
    @(negedge clk);
    a = ai; b = bi; start = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      check("busy_run", 32'(busy), 32'd1);
      if (done) begin lat = k; break; end
    end
    if (lat == 0) check("done_timeout", 32'd0, 32'd1);
    else begin
      check("latency", 32'(lat), 32'd8);
      @(posedge clk); #1;
      check("busy_drop", 32'(busy), 32'd0);
      check("p_held", 32'(p), 32'(exp));
    end
  endtask

  initial begin
    vecs[0] = '{8'h0F, 8'h0F, 16'h00E1};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{8'h00, 8'h55, 16'h0000};
    vecs[3] = '{8'h55, 8'h00, 16'h0000};
    vecs[4] = '{8'h12, 8'h34, 16'h03A8};
    vecs[5] = '{8'h01, 8'hFF, 16'h00FF};
    vecs[6] = '{8'h80, 8'h80, 16'h4000};
    vecs[7] = '{8'hA5, 8'h5A, 16'h3A02};

    nrst = 1'b0; start = 1'b0; a = '0; b = '0;
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_p",    32'(p),    32'd0);
    @(negedge clk) nrst = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].p);

    // Abort mid-RUN: outputs clear immediately and no done follows.
    @(negedge clk);
    a = 8'h12; b = 8'h34; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_p",    32'(p),    32'd0);
    @(negedge clk);
    @(negedge clk) nrst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      check("abort_no_done", 32'(done), 32'd0);
    end
    check("abort_p_after", 32'(p), 32'd0);
    run_op(8'h12, 8'h34, 16'h03A8);

    // start held high: back-to-back issue every 10 cycles, a/b wobble mid-run.
    @(negedge clk);
    a = 8'd3; b = 8'd5; start = 1'b1;
    repeat (3) sb.push_back(16'h000F);
    @(posedge clk);
    for (int c = 1; c <= 29; c++) begin
      @(posedge clk); #1;
      check("held_done", 32'(done), 32'((c % 10) == 8));
      if ((c % 10) >= 2 && (c % 10) <= 6) begin a = 8'hAA; b = 8'hBB; end
      else begin a = 8'd3; b = 8'd5; end
      if (c == 25) start = 1'b0;
    end
    @(posedge clk); #1;
    check("held_idle", 32'(busy), 32'd0);

    // start during RUN and DONE is ignored and not queued.
    @(negedge clk);
    a = 8'h21; b = 8'h13; start = 1'b1;
    sb.push_back(16'h0273);
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      check("ign_done", 32'(done), 32'(c == 8));
      check("ign_busy", 32'(busy), 32'(c <= 8));
      if (c == 3) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
      if (c == 9) start = 1'b0;
    end
    check("ign_p", 32'(p), 32'h0273);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
